// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32/RV64 immediate decoder feeding a 2-entry FIFO with tag sideband.
// The head entry drives out_* directly from registers; the tail entry backs it up.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      illegal_cnt
);
  localparam bit RV64 = (XLEN == 64);
  logic [6:0]       op;
  logic             is_r, is_i, is_s, is_b, is_u, is_j;
  logic [2:0]       dec_fmt;
  logic [31:0]      dec_imm32;
  logic [XLEN-1:0]  dec_imm;
  logic             push, pop;
  logic [1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]  hd_imm_q, tl_imm_q;
  logic [2:0]       hd_fmt_q, tl_fmt_q;
  logic [TAG_W-1:0] hd_tag_q, tl_tag_q;
  logic [15:0]      ill_q;
  assign op   = in_instr[6:0];
  assign is_r = (op == 7'b0110011) || (RV64 && op == 7'b0111011);
  assign is_i = (op == 7'b0000011) || (op == 7'b0010011) || (op == 7'b1100111) ||
                (op == 7'b1110011) || (RV64 && op == 7'b0011011);
  assign is_s = (op == 7'b0100011);
  assign is_b = (op == 7'b1100011);
  assign is_u = (op == 7'b0110111) || (op == 7'b0010111);
  assign is_j = (op == 7'b1101111);
  always_comb begin
    dec_fmt   = is_r ? 3'd0 : is_i ? 3'd1 : is_s ? 3'd2 : is_b ? 3'd3 :
                is_u ? 3'd4 : is_j ? 3'd5 : 3'd7;
    dec_imm32 = is_i ? {{20{in_instr[31]}}, in_instr[31:20]} :
                is_s ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
                is_b ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0} :
                is_u ? {in_instr[31:12], 12'b0} :
                is_j ? {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0} :
                32'd0;
  end
  // All 32-bit immediates carry instr[31] at bit 31, so a signed widen is the sign extension.
  assign dec_imm     = XLEN'($signed(dec_imm32));
  assign in_ready    = rst_n && (cnt_q < 2'd2) && !flush;
  assign out_valid   = (cnt_q != 2'd0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};
  assign out_imm     = hd_imm_q;
  assign out_fmt     = hd_fmt_q;
  assign out_tag     = hd_tag_q;
  assign illegal_cnt = ill_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 2'd0;
      hd_imm_q <= '0;
      hd_fmt_q <= 3'd0;
      hd_tag_q <= '0;
      tl_imm_q <= '0;
      tl_fmt_q <= 3'd0;
      tl_tag_q <= '0;
      ill_q    <= 16'd0;
    end else if (flush) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      if (push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) begin
        hd_imm_q <= dec_imm;
        hd_fmt_q <= dec_fmt;
        hd_tag_q <= in_tag;
      end else if (pop && cnt_q == 2'd2) begin
        hd_imm_q <= tl_imm_q;
        hd_fmt_q <= tl_fmt_q;
        hd_tag_q <= tl_tag_q;
      end
      if (push && cnt_q == 2'd1 && !pop) begin
        tl_imm_q <= dec_imm;
        tl_fmt_q <= dec_fmt;
        tl_tag_q <= in_tag;
      end
      if (push && dec_fmt == 3'd7 && ill_q != 16'hFFFF) ill_q <= ill_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives an XLEN=32 and an XLEN=64 instance with identical stimulus
// and checks both against constant decode vectors through a FIFO scoreboard.
module tb_imm_gen_pipe;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0;
  logic [7:0]  in_tag = 0;
  logic        rdy32, rdy64, v32, v64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [7:0]  tag32, tag64;
  logic [15:0] ill32_o, ill64_o;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_tag(tag32), .illegal_cnt(ill32_o));
  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_tag(tag64), .illegal_cnt(ill64_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
  } vec_t;
  typedef struct {
    int         idx;
    logic [7:0] tag;
  } ent_t;

  vec_t tbl[16];
  ent_t q[$];
  int   total = 0, bad = 0;
  int   m_ill32 = 0, m_ill64 = 0;
  int   cur_idx = 0;
  bit   pushed;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int idx, input logic [7:0] tag);
    cur_idx  = idx;
    in_instr = tbl[idx].instr;
    in_tag   = tag;
    in_valid = 1;
  endtask

  // One cycle: sample just after the falling edge, update the model, advance to next falling edge.
  task automatic tick();
    int   sz;
    ent_t e;
    #1;
    sz = q.size();
    chk("in_ready32", rdy32, sz < 2 && !flush);
    chk("in_ready64", rdy64, sz < 2 && !flush);
    chk("out_valid32", v32, sz != 0);
    chk("out_valid64", v64, sz != 0);
    chk("illegal_cnt32", ill32_o, m_ill32);
    chk("illegal_cnt64", ill64_o, m_ill64);
    if (sz != 0) begin
      e = q[0];
      chk("imm32", imm32, tbl[e.idx].imm32);
      chk("fmt32", fmt32, tbl[e.idx].fmt32);
      chk("tag32", tag32, e.tag);
      chk("imm64", imm64, tbl[e.idx].imm64);
      chk("fmt64", fmt64, tbl[e.idx].fmt64);
      chk("tag64", tag64, e.tag);
    end
    pushed = 0;
    if (flush) q.delete();
    else begin
      if (sz != 0 && out_ready) void'(q.pop_front());
      if (in_valid && sz < 2) begin
        q.push_back('{cur_idx, in_tag});
        pushed = 1;
        if (tbl[cur_idx].fmt32 == 3'd7 && m_ill32 < 65535) m_ill32++;
        if (tbl[cur_idx].fmt64 == 3'd7 && m_ill64 < 65535) m_ill64++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n, cyc, ill_before;
    tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1};
    tbl[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2};
    tbl[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 64'hFFFFFFFFFFFFFFF8, 3'd3};
    tbl[3]  = '{32'h123450B7, 32'h12345000, 3'd4, 64'h0000000012345000, 3'd4};
    tbl[4]  = '{32'h0000006F, 32'h00000000, 3'd5, 64'h0000000000000000, 3'd5};
    tbl[5]  = '{32'h800000B7, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4};
    tbl[6]  = '{32'h0000009B, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd1};
    tbl[7]  = '{32'h0000003B, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd0};
    tbl[8]  = '{32'hFFFFFFB3, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0};
    tbl[9]  = '{32'h00000000, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd7};
    tbl[10] = '{32'h80000067, 32'hFFFFF800, 3'd1, 64'hFFFFFFFFFFFFF800, 3'd1};
    tbl[11] = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 64'hFFFFFFFFFFFFFFFC, 3'd5};
    tbl[12] = '{32'h00001017, 32'h00001000, 3'd4, 64'h0000000000001000, 3'd4};
    tbl[13] = '{32'h00402083, 32'h00000004, 3'd1, 64'h0000000000000004, 3'd1};
    tbl[14] = '{32'h00100073, 32'h00000001, 3'd1, 64'h0000000000000001, 3'd1};
    tbl[15] = '{32'h0000007F, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd7};

    #3;
    chk("rst_in_ready", rdy32, 0);
    chk("rst_out_valid", v32, 0);
    chk("rst_out_imm", imm64, 0);
    chk("rst_out_fmt", fmt32, 0);
    chk("rst_out_tag", tag32, 0);
    chk("rst_illegal_cnt", ill32_o, 0);
    @(negedge clk);
    rst_n = 1;
    tick();

    // Table sweep at full throughput
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      drive(i, 8'h10 + 8'(i));
      tick();
    end
    in_valid = 0;
    repeat (3) tick();

    // Random traffic with occasional flush
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 1) == 1) drive(int'($urandom_range(0, 15)), 8'($urandom));
      else in_valid = 0;
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 19) == 0);
      tick();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    repeat (3) tick();

    // Backpressure: three offers, only two fit until the consumer releases
    out_ready = 0; n = 0; cyc = 0;
    while (n < 3 && cyc < 20) begin
      drive(n + 1, 8'hA0 + 8'(n));
      out_ready = (cyc >= 4);
      tick();
      if (pushed) n++;
      cyc++;
    end
    chk("bp_all_accepted", n, 3);
    in_valid = 0; out_ready = 1;
    repeat (4) tick();

    // Two illegal pushes, then flush a full FIFO
    out_ready = 0;
    ill_before = m_ill32;
    drive(9, 8'hC1); tick();
    drive(9, 8'hC2); tick();
    in_valid = 0; flush = 1;
    tick();
    flush = 0;
    tick();
    chk("flush_keeps_ill32", ill32_o, ill_before + 2);
    chk("flush_out_valid", v32, 0);

    // Asynchronous reset between edges with a full FIFO
    drive(9, 8'hD1); tick();
    drive(0, 8'hD2); tick();
    in_valid = 0;
    chk("full_before_reset", v64, 1);
    #2 rst_n = 0;
    #1;
    chk("areset_out_valid32", v32, 0);
    chk("areset_out_valid64", v64, 0);
    chk("areset_ill32", ill32_o, 0);
    chk("areset_ill64", ill64_o, 0);
    chk("areset_in_ready", rdy32, 0);
    chk("areset_out_imm", imm32, 0);
    chk("areset_out_tag", tag64, 0);
    q.delete(); m_ill32 = 0; m_ill64 = 0;
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    tick();
    drive(3, 8'hE0); tick();
    in_valid = 0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
